// File: rtl/iob_tdp_ram_be_init.sv
// iob_tdp_ram_be_init
// Single-clock true dual-port RAM with per-column byte enables and a
// built-in clear engine that fills every word with {NUM_COL{INIT_VAL}}
// after reset or on init_i.
//
// Handshake: there is no backpressure. A port access is accepted on a
// rising edge when enX=1 and the block is in RUN (busy_o=0). Its read data
// appears on doutX one cycle later (two with the output register) and holds
// until the next accepted access on that port. Accesses presented while
// busy_o=1 are dropped.
//
// Optional feature macro: IOB_TDP_RAM_OREG_EN adds an output pipeline
// register on doutA/doutB (read latency 2).
`timescale 1ns/1ps

module iob_tdp_ram_be_init #(
  parameter int                   NUM_COL   = 4,
  parameter int                   COL_WIDTH = 8,
  parameter int                   DATA_W    = NUM_COL*COL_WIDTH,
  parameter int                   ADDR_W    = 10,
  parameter logic [COL_WIDTH-1:0] INIT_VAL  = '0,
  parameter int                   RDW_MODE  = 0
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                init_i,
  output logic                busy_o,
  output logic                collision_o,
  input  logic                enA,
  input  logic [NUM_COL-1:0]  weA,
  input  logic [ADDR_W-1:0]   addrA,
  input  logic [DATA_W-1:0]   dinA,
  output logic [DATA_W-1:0]   doutA,
  input  logic                enB,
  input  logic [NUM_COL-1:0]  weB,
  input  logic [ADDR_W-1:0]   addrB,
  input  logic [DATA_W-1:0]   dinB,
  output logic [DATA_W-1:0]   doutB
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d, cnt_inc;
  logic                run, en_a, en_b;
  logic [NUM_COL-1:0]  wr_a, wr_b;
  logic [DATA_W-1:0]   rd_a_word, rd_b_word;
  logic [DATA_W-1:0]   dout_a_q, dout_a_d, dout_b_q, dout_b_d;
  logic                coll_q, coll_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Sweep FSM, port gating and collision detection
  always_comb begin
    run     = (state_q == ST_RUN);
    en_a    = enA & run;
    en_b    = enB & run;
    wr_a    = weA & {NUM_COL{en_a}};
    wr_b    = weB & {NUM_COL{en_b}};
    coll_d  = en_a & en_b & (addrA == addrB) & (|(wr_a & wr_b));
    cnt_inc = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_inc;
        // Extra counter bit flags that the last address has just been written
        if (cnt_inc[ADDR_W]) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (init_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Read words: old data, or own-port merged data in write-first mode
  always_comb begin
    rd_a_word = mem[addrA];
    rd_b_word = mem[addrB];
    if (RDW_MODE == 1) begin
      for (int c = 0; c < NUM_COL; c++) begin
        if (wr_a[c]) rd_a_word[c*COL_WIDTH +: COL_WIDTH] = dinA[c*COL_WIDTH +: COL_WIDTH];
        if (wr_b[c]) rd_b_word[c*COL_WIDTH +: COL_WIDTH] = dinB[c*COL_WIDTH +: COL_WIDTH];
      end
    end
    dout_a_d = en_a ? rd_a_word : dout_a_q;
    dout_b_d = en_b ? rd_b_word : dout_b_q;
  end

  // Control and read registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      dout_a_q <= '0;
      dout_b_q <= '0;
      coll_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
      coll_q   <= coll_d;
    end
  end

  // Array writes: clear sweep, else port B then port A so A wins shared columns
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt_q[ADDR_W-1:0]] <= {NUM_COL{INIT_VAL}};
    end else begin
      for (int c = 0; c < NUM_COL; c++) begin
        if (wr_b[c]) mem[addrB][c*COL_WIDTH +: COL_WIDTH] <= dinB[c*COL_WIDTH +: COL_WIDTH];
        if (wr_a[c]) mem[addrA][c*COL_WIDTH +: COL_WIDTH] <= dinA[c*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  assign busy_o      = ~run;
  assign collision_o = coll_q;

`ifdef IOB_TDP_RAM_OREG_EN
  logic              en_a_prev_q, en_b_prev_q;
  logic [DATA_W-1:0] oreg_a_q, oreg_a_d, oreg_b_q, oreg_b_d;

  // Output register follows the read register one cycle after an access
  always_comb begin
    oreg_a_d = en_a_prev_q ? dout_a_q : oreg_a_q;
    oreg_b_d = en_b_prev_q ? dout_b_q : oreg_b_q;
  end

  // Output pipeline registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      en_a_prev_q <= 1'b0;
      en_b_prev_q <= 1'b0;
      oreg_a_q    <= '0;
      oreg_b_q    <= '0;
    end else begin
      en_a_prev_q <= en_a;
      en_b_prev_q <= en_b;
      oreg_a_q    <= oreg_a_d;
      oreg_b_q    <= oreg_b_d;
    end
  end

  assign doutA = oreg_a_q;
  assign doutB = oreg_b_q;
`else
  assign doutA = dout_a_q;
  assign doutB = dout_b_q;
`endif

endmodule

// File: tb/tb_iob_tdp_ram_be_init.sv
// Directed bench for iob_tdp_ram_be_init. Two instances share stimulus:
// d0 clears to 0x00 and is read-first, d1 clears to 0x5A and is write-first.
`timescale 1ns/1ps

module tb_iob_tdp_ram_be_init;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        init_i = 1'b0;
  logic        enA = 1'b0, enB = 1'b0;
  logic [3:0]  weA = '0, weB = '0;
  logic [3:0]  addrA = '0, addrB = '0;
  logic [31:0] dinA = '0, dinB = '0;

  logic        d0_busy, d0_coll, d1_busy, d1_coll;
  logic [31:0] d0_doutA, d0_doutB, d1_doutA, d1_doutB;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  iob_tdp_ram_be_init #(.NUM_COL(4), .COL_WIDTH(8), .ADDR_W(4),
                        .INIT_VAL(8'h00), .RDW_MODE(0)) dut0 (
    .clk(clk), .arst_n(arst_n), .init_i(init_i), .busy_o(d0_busy),
    .collision_o(d0_coll),
    .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(d0_doutA),
    .enB(enB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(d0_doutB)
  );

  iob_tdp_ram_be_init #(.NUM_COL(4), .COL_WIDTH(8), .ADDR_W(4),
                        .INIT_VAL(8'h5A), .RDW_MODE(1)) dut1 (
    .clk(clk), .arst_n(arst_n), .init_i(init_i), .busy_o(d1_busy),
    .collision_o(d1_coll),
    .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(d1_doutA),
    .enB(enB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(d1_doutB)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Extra cycle so the output register (when built in) catches up
  task automatic settle();
`ifdef IOB_TDP_RAM_OREG_EN
    step();
`endif
  endtask

  task automatic idle_ports();
    enA = 1'b0; enB = 1'b0; weA = '0; weB = '0;
  endtask

  task automatic access(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                        input logic [31:0] da, input logic eb, input logic [3:0] wb,
                        input logic [3:0] ab, input logic [31:0] db);
    enA = ea; weA = wa; addrA = aa; dinA = da;
    enB = eb; weB = wb; addrB = ab; dinB = db;
    step();
    idle_ports();
    settle();
  endtask

  // Counts cycles with busy high on both instances; bounded
  task automatic wait_clear(output int cycles);
    cycles = 0;
    while ((d0_busy || d1_busy) && cycles < 100) begin
      step();
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 arst_n = 1'b0;
    #1;
    n_tests++;
    if (d0_busy !== 1'b1 || d1_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b want 1/1", d0_busy, d1_busy);
    end
    n_tests++;
    if (d0_doutA !== 32'h0 || d0_doutB !== 32'h0 || d1_doutA !== 32'h0 || d1_doutB !== 32'h0) begin
      n_fail++; $display("FAIL reset_dout: got %h %h %h %h want 0", d0_doutA, d0_doutB, d1_doutA, d1_doutB);
    end
    n_tests++;
    if (d0_coll !== 1'b0 || d1_coll !== 1'b0) begin
      n_fail++; $display("FAIL reset_coll: got %b/%b want 0/0", d0_coll, d1_coll);
    end
    step();
    step();
  endtask

  task automatic test_clear();
    int cyc;
    arst_n = 1'b1;
    wait_clear(cyc);
    n_tests++;
    if (cyc !== 16) begin
      n_fail++; $display("FAIL clear_len: got %0d cycles want 16", cyc);
    end
    for (int i = 0; i < 16; i++) begin
      access(1'b1, 4'h0, i[3:0], 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
      n_tests++;
      if (d0_doutA !== 32'h00000000 || d1_doutA !== 32'h5A5A5A5A) begin
        n_fail++; $display("FAIL clear_read a=%0d: got %h/%h want 00000000/5a5a5a5a", i, d0_doutA, d1_doutA);
      end
    end
    access(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0);
    n_tests++;
    if (d0_doutB !== 32'h00000000 || d1_doutB !== 32'h5A5A5A5A) begin
      n_fail++; $display("FAIL clear_read_b9: got %h/%h want 00000000/5a5a5a5a", d0_doutB, d1_doutB);
    end
  endtask

  task automatic test_byte_enable();
    access(1'b1, 4'b0101, 4'd3, 32'hAABBCCDD, 1'b0, 4'h0, 4'h0, 32'h0);
    n_tests++;
    if (d0_doutA !== 32'h00000000 || d1_doutA !== 32'h5ABB5ADD) begin
      n_fail++; $display("FAIL be_write_rdw: got %h/%h want 00000000/5abb5add", d0_doutA, d1_doutA);
    end
    access(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
    n_tests++;
    if (d0_doutB !== 32'h00BB00DD || d1_doutB !== 32'h5ABB5ADD) begin
      n_fail++; $display("FAIL be_read_b3: got %h/%h want 00bb00dd/5abb5add", d0_doutB, d1_doutB);
    end
  endtask

  task automatic test_collision();
    // Full overlap: A wins every column, collision pulse
    enA = 1'b1; weA = 4'b1111; addrA = 4'd5; dinA = 32'h11111111;
    enB = 1'b1; weB = 4'b0011; addrB = 4'd5; dinB = 32'h22222222;
    step();
    idle_ports();
    n_tests++;
    if (d0_coll !== 1'b1 || d1_coll !== 1'b1) begin
      n_fail++; $display("FAIL coll_pulse: got %b/%b want 1/1", d0_coll, d1_coll);
    end
    step();
    n_tests++;
    if (d0_coll !== 1'b0 || d1_coll !== 1'b0) begin
      n_fail++; $display("FAIL coll_one_cycle: got %b/%b want 0/0", d0_coll, d1_coll);
    end
    access(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    n_tests++;
    if (d0_doutB !== 32'h11111111 || d1_doutB !== 32'h11111111) begin
      n_fail++; $display("FAIL coll_a_wins: got %h/%h want 11111111", d0_doutB, d1_doutB);
    end
    // Disjoint columns: both land, no pulse
    enA = 1'b1; weA = 4'b1100; addrA = 4'd5; dinA = 32'h11111111;
    enB = 1'b1; weB = 4'b0011; addrB = 4'd5; dinB = 32'h22222222;
    step();
    idle_ports();
    n_tests++;
    if (d0_coll !== 1'b0 || d1_coll !== 1'b0) begin
      n_fail++; $display("FAIL disjoint_no_coll: got %b/%b want 0/0", d0_coll, d1_coll);
    end
    settle();
    access(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    n_tests++;
    if (d0_doutA !== 32'h11112222 || d1_doutA !== 32'h11112222) begin
      n_fail++; $display("FAIL disjoint_merge: got %h/%h want 11112222", d0_doutA, d1_doutA);
    end
  endtask

  task automatic test_rdw();
    access(1'b1, 4'b1111, 4'd5, 32'h11111111, 1'b0, 4'h0, 4'h0, 32'h0);
    access(1'b1, 4'b1111, 4'd5, 32'h33333333, 1'b1, 4'h0, 4'd5, 32'h0);
    n_tests++;
    if (d0_doutA !== 32'h11111111 || d1_doutA !== 32'h33333333) begin
      n_fail++; $display("FAIL rdw_same_port: got %h/%h want 11111111/33333333", d0_doutA, d1_doutA);
    end
    n_tests++;
    if (d0_doutB !== 32'h11111111 || d1_doutB !== 32'h11111111) begin
      n_fail++; $display("FAIL rdw_cross_port: got %h/%h want 11111111", d0_doutB, d1_doutB);
    end
    access(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    n_tests++;
    if (d0_doutB !== 32'h33333333 || d1_doutB !== 32'h33333333) begin
      n_fail++; $display("FAIL rdw_visible: got %h/%h want 33333333", d0_doutB, d1_doutB);
    end
  endtask

  task automatic test_reinit_reset();
    int cyc;
    init_i = 1'b1;
    step();
    init_i = 1'b0;
    n_tests++;
    if (d0_busy !== 1'b1 || d1_busy !== 1'b1) begin
      n_fail++; $display("FAIL init_enter: got busy %b/%b want 1/1", d0_busy, d1_busy);
    end
    for (int i = 0; i < 7; i++) step();
    arst_n = 1'b0;
    #1;
    n_tests++;
    if (d0_doutA !== 32'h0 || d0_doutB !== 32'h0 || d1_doutA !== 32'h0 || d1_doutB !== 32'h0) begin
      n_fail++; $display("FAIL midsweep_reset_dout: got %h %h %h %h want 0", d0_doutA, d0_doutB, d1_doutA, d1_doutB);
    end
    n_tests++;
    if (d0_busy !== 1'b1 || d1_busy !== 1'b1) begin
      n_fail++; $display("FAIL midsweep_reset_busy: got %b/%b want 1/1", d0_busy, d1_busy);
    end
    #1 arst_n = 1'b1;
    // Writes presented during the sweep must be ignored
    enA = 1'b1; weA = 4'b1111; addrA = 4'd2; dinA = 32'hFFFFFFFF;
    enB = 1'b1; weB = 4'b1111; addrB = 4'd7; dinB = 32'hEEEEEEEE;
    wait_clear(cyc);
    idle_ports();
    n_tests++;
    if (cyc !== 16) begin
      n_fail++; $display("FAIL resweep_len: got %0d cycles want 16", cyc);
    end
    for (int i = 0; i < 16; i++) begin
      access(1'b1, 4'h0, i[3:0], 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
      n_tests++;
      if (d0_doutA !== 32'h00000000 || d1_doutA !== 32'h5A5A5A5A) begin
        n_fail++; $display("FAIL resweep_read a=%0d: got %h/%h want 00000000/5a5a5a5a", i, d0_doutA, d1_doutA);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clear();
    test_byte_enable();
    test_collision();
    test_rdw();
    test_reinit_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
